// File: rtl/tl_pkg.sv
// Shared types and widths for the traffic-light Q-learning agent.
// Holds policy-generator FSM encodings and the Q-table address layout.
package tl_pkg;

    localparam int unsigned S_W    = 12;
    localparam int unsigned A_W    = 2;
    localparam int unsigned Q_W    = 16;
    localparam int unsigned N_ACT  = 2 ** A_W;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned K_W    = A_W + 1;
    localparam int unsigned ADDR_W = S_W + A_W;

    typedef enum logic [1:0] {
        PG_IDLE  = 2'd0,
        PG_FETCH = 2'd1,
        PG_DRAIN = 2'd2,
        PG_DONE  = 2'd3
    } pg_state_t;

    typedef struct packed {
        logic [S_W-1:0] state;
        logic [A_W-1:0] act;
    } q_addr_t;

    // Q-table address is {state, action}
    function automatic logic [ADDR_W-1:0] q_addr_of(input logic [S_W-1:0] s,
                                                    input logic [A_W-1:0] a);
        q_addr_t t;
        t.state = s;
        t.act   = a;
        return t;
    endfunction

endpackage

// File: rtl/policy_gen_if.sv
// Policy generator bus: CU control, Q-table read port and selection results.
interface policy_gen_if;
    import tl_pkg::*;

    logic                  pg;
    logic                  nxt;
    logic                  asel;
    logic [A_W-1:0]        arand;
    logic [S_W-1:0]        state_in;
    logic                  q_ren;
    logic [ADDR_W-1:0]     q_addr;
    logic signed [Q_W-1:0] q_rdata;
    logic [A_W-1:0]        action;
    logic signed [Q_W-1:0] q_sel;
    logic signed [Q_W-1:0] q_max;
    logic                  valid;
    logic                  busy;

    modport master (
        output pg, nxt, asel, arand, state_in, q_rdata,
        input  q_ren, q_addr, action, q_sel, q_max, valid, busy
    );

    modport slave (
        input  pg, nxt, asel, arand, state_in, q_rdata,
        output q_ren, q_addr, action, q_sel, q_max, valid, busy
    );

endinterface

// File: rtl/q_argmax.sv
// Signed running max/argmax register; strict compare keeps the lowest index on ties.
module q_argmax
    import tl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  upd,
    input  logic signed [Q_W-1:0] din,
    input  logic [A_W-1:0]        idx,
    output logic signed [Q_W-1:0] max_q,
    output logic [A_W-1:0]        arg_q,
    output logic signed [Q_W-1:0] max_c,
    output logic [A_W-1:0]        arg_c
);

    always_comb begin
        max_c = max_q;
        arg_c = arg_q;
        if (clr) begin
            max_c = '0;
            arg_c = '0;
        end else if (load || (upd && (din > max_q))) begin
            max_c = din;
            arg_c = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_c;
            arg_q <= arg_c;
        end
    end

endmodule

// File: rtl/policy_gen.sv
// Epsilon-greedy policy generator: scans all Q(s,a), picks greedy argmax or the
// CU random action, and returns Q(s,a_chosen) and max_a Q(s,a).
module policy_gen
    import tl_pkg::*;
(
    input logic         clk,
    input logic         rst,
    policy_gen_if.slave bus
);

    pg_state_t state, state_n;
    logic [K_W-1:0] k, k_n;
    logic pg_d, launch;

    logic [S_W-1:0] s_lat;
    logic           asel_lat;
    logic [A_W-1:0] arand_lat;

    logic [RD_LAT-1:0]          dl_ren;
    logic [RD_LAT-1:0][A_W-1:0] dl_k;
    logic                       cap;
    logic [A_W-1:0]             cap_k;

    logic signed [Q_W-1:0] qsel_q, qsel_c;
    logic signed [Q_W-1:0] max_q, max_c;
    logic [A_W-1:0]        arg_q, arg_c;

    logic                  q_ren_n, valid_n, busy_n, res_en;
    logic [ADDR_W-1:0]     q_addr_n;
    logic [A_W-1:0]        action_n;
    logic signed [Q_W-1:0] q_sel_n, q_max_n;

    assign launch = (state == PG_IDLE) && bus.pg && (!pg_d || bus.nxt);
    assign cap    = dl_ren[RD_LAT-1] && ((state == PG_FETCH) || (state == PG_DRAIN));
    assign cap_k  = dl_k[RD_LAT-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PG_IDLE;
            k     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end
    end

    // Next state; k counts issued reads in FETCH and wait cycles in DRAIN
    always_comb begin
        state_n = state;
        k_n     = k;
        case (state)
            PG_IDLE: begin
                if (launch) begin
                    state_n = PG_FETCH;
                    k_n     = '0;
                end
            end
            PG_FETCH: begin
                if (!bus.pg) begin
                    state_n = PG_IDLE;
                end else if (k == K_W'(N_ACT - 1)) begin
                    state_n = PG_DRAIN;
                    k_n     = '0;
                end else begin
                    k_n = k + K_W'(1);
                end
            end
            PG_DRAIN: begin
                if (!bus.pg) begin
                    state_n = PG_IDLE;
                end else if (k == K_W'(RD_LAT - 1)) begin
                    state_n = PG_DONE;
                end else begin
                    k_n = k + K_W'(1);
                end
            end
            PG_DONE: state_n = PG_IDLE;
            default: state_n = PG_IDLE;
        endcase
    end

    // Output next values, registered below
    always_comb begin
        q_ren_n  = 1'b0;
        q_addr_n = '0;
        valid_n  = 1'b0;
        res_en   = 1'b0;
        busy_n   = (state_n != PG_IDLE);
        action_n = asel_lat ? arg_c : arand_lat;
        q_sel_n  = asel_lat ? max_c : qsel_c;
        q_max_n  = max_c;
        if (state_n == PG_FETCH) begin
            q_ren_n  = 1'b1;
            q_addr_n = q_addr_of(launch ? bus.state_in : s_lat, k_n[A_W-1:0]);
        end
        if (state_n == PG_DONE) begin
            valid_n = 1'b1;
            res_en  = 1'b1;
        end
    end

    // Explore-mode capture of Q(s, arand)
    always_comb begin
        qsel_c = qsel_q;
        if (cap && (cap_k == arand_lat)) begin
            qsel_c = bus.q_rdata;
        end
    end

    q_argmax u_argmax (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .load  (cap && (cap_k == '0)),
        .upd   (cap),
        .din   (bus.q_rdata),
        .idx   (cap_k),
        .max_q (max_q),
        .arg_q (arg_q),
        .max_c (max_c),
        .arg_c (arg_c)
    );

    // Launch latches and read-index delay line, flushed whenever the FSM idles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pg_d      <= 1'b0;
            s_lat     <= '0;
            asel_lat  <= 1'b0;
            arand_lat <= '0;
            dl_ren    <= '0;
            dl_k      <= '0;
            qsel_q    <= '0;
        end else begin
            pg_d   <= bus.pg;
            qsel_q <= qsel_c;
            dl_k   <= (RD_LAT * A_W)'({dl_k, k[A_W-1:0]});
            if (state_n == PG_IDLE) begin
                dl_ren <= '0;
            end else begin
                dl_ren <= RD_LAT'({dl_ren, bus.q_ren});
            end
            if (launch) begin
                s_lat     <= bus.state_in;
                asel_lat  <= bus.asel;
                arand_lat <= bus.arand;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.q_ren  <= 1'b0;
            bus.q_addr <= '0;
            bus.valid  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.action <= '0;
            bus.q_sel  <= '0;
            bus.q_max  <= '0;
        end else begin
            bus.q_ren  <= q_ren_n;
            bus.q_addr <= q_addr_n;
            bus.valid  <= valid_n;
            bus.busy   <= busy_n;
            if (res_en) begin
                bus.action <= action_n;
                bus.q_sel  <= q_sel_n;
                bus.q_max  <= q_max_n;
            end
        end
    end

endmodule
